instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Front-end fetch stage that owns the program counter and issues word-aligned fetch requests to instruction memory over a valid/ready request channel with variable-latency, in-order responses. Returned words go into a small in-order queue. The queue presents {pc, instruction} to the downstream instruction register / decode stage via a valid/ready handshake. A redirect input (branch/jump) re-steers fetch, flushes queued words and discards responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
QUEUE_DEPTH, 4, instruction queue entries; power of two, 2..16.
ADDR_WIDTH, 32, width of PC and memory address.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset (asserted at 0).
mem_req_valid  output  1  fetch request valid.
mem_req_ready  input  1  memory accepts request this cycle.
mem_req_addr  output  ADDR_WIDTH  fetch address (current PC).
mem_resp_valid  input  1  one response word valid (in request order).
mem_resp_data  input  32  fetched instruction word.
redirect_valid  input  1  one-cycle pulse: resteer fetch.
redirect_pc  input  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0).
inst_valid  output  1  queue head valid.
inst_ready  input  1  downstream consumes head.
inst_data  output  32  instruction at queue head.
inst_pc  output  ADDR_WIDTH  PC of that instruction.

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_PC, queue empty, outstanding=0, discard=0, state=RUN. Outputs: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0. Reset mid-transfer drops everything; responses for pre-reset requests are the memory's responsibility.
- States: RUN (issue requests and accept responses), DRAIN (discard stale responses; no requests issued).
- Credit: mem_req_valid = (state==RUN) & ~redirect_valid & (outstanding + queue_count < QUEUE_DEPTH). A queue slot therefore always exists for each response; no response backpressure.
- Request accept (valid & ready): outstanding+1 and pc+4, which wraps modulo 2^ADDR_WIDTH. mem_req_addr=pc and stays stable while valid & ~ready.
- Response in RUN: push {pc_tag, data}. pc_tag comes from an internal response-PC counter that advances by 4 per response. outstanding-1.
- Pop: inst_valid & inst_ready removes the head. Simultaneous push and pop keeps the count. Output is registered from the queue head, with zero added latency beyond the queue: a response accepted in cycle N is visible at inst_valid in cycle N+1.
- Redirect (redirect_valid=1, any state): at the next edge pc and the response-PC counter <= {redirect_pc[ADDR_WIDTH-1:2],2'b00} and the queue is flushed (inst_valid=0 in N+1). A pop in the same cycle is ignored. discard <= outstanding, excluding any response arriving in the redirect cycle, which is itself dropped. Next state is DRAIN if that discard count is >0, else RUN.
- DRAIN: each mem_resp_valid is dropped and decrements discard and outstanding. The edge where discard reaches 0 goes to RUN, so the first new request is in the following cycle.
- A redirect during DRAIN reloads pc and keeps discarding the remaining outstanding responses.
- mem_resp_valid with outstanding==0 is a protocol error and is ignored (assertion in simulation).

Optional Feature:
Macro FETCH_STATS_EN. When defined, two extra output ports are added: stat_fetched (32-bit, counts instructions popped to downstream) and stat_discarded (32-bit, counts responses dropped in DRAIN or in a redirect cycle). Both reset to 0, saturate at 32'hFFFF_FFFF and are never cleared by redirect. When undefined, these ports and counters do not exist and the core behaviour is identical.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle memory, inst_ready=1 -> requests at 0,4,8,12; inst_pc 0,4,8,12 in order with matching data; no gaps after the pipeline fills.
- inst_ready=0, memory always ready, QUEUE_DEPTH=4 -> exactly 4 requests (0..12) issued, mem_req_valid then held 0, inst_valid=1 holding pc 0; raising inst_ready resumes at addr 16.
- mem_req_ready=0 for 3 cycles -> mem_req_addr stable at 0 with valid held; the request is accepted on the first ready cycle.
- 2 requests outstanding (3-cycle latency), redirect_pc=32'h0000_0103 -> queue flushed next cycle; both stale responses dropped; next request addr 32'h100; first inst_pc 32'h100.
- redirect with outstanding=0 and a concurrent pop -> no DRAIN, request at the new PC in the following cycle; popped entry not counted.
- reset asserted mid-DRAIN -> outputs return to reset values immediately (asynchronously), without waiting for a clock edge; with FETCH_STATS_EN both counters are 0, and after 3 drained responses stat_discarded=3.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, credit-limited fetch requester and in-order instruction queue
// Optional FETCH_STATS_EN adds saturating fetched/discarded counters.
module instruction_fetch_unit #(
   parameter int unsigned             ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = '0,
   parameter int unsigned             QUEUE_DEPTH = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   input  logic                    mem_resp_valid,
   input  logic [31:0]             mem_resp_data,
   input  logic                    redirect_valid,
   input  logic [ADDR_WIDTH-1:0]   redirect_pc,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [31:0]             inst_data,
   output logic [ADDR_WIDTH-1:0]   inst_pc
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]             stat_fetched,
   output logic [31:0]             stat_discarded
`endif
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   resp_pc_q, resp_pc_d;
   logic [CW-1:0]           outst_q, outst_d;
   logic [CW-1:0]           discard_q, discard_d;
   logic [CW-1:0]           count_q, count_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;

   logic [ADDR_WIDTH-1:0]   q_pc_q   [QUEUE_DEPTH];
   logic [31:0]             q_data_q [QUEUE_DEPTH];

   logic                    resp_ok;
   logic                    credit_ok;
   logic                    req_fire;
   logic                    push;
   logic                    drop;
   logic                    pop;
   logic                    unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Responses with nothing outstanding are protocol errors and are ignored.
   assign resp_ok   = mem_resp_valid & (outst_q != '0);
   assign credit_ok = ({1'b0, outst_q} + {1'b0, count_q}) < (CW+1)'(QUEUE_DEPTH);

   // Gating with reset keeps the request low while reset is held asynchronously.
   assign mem_req_valid = reset & (state_q == RUN) & ~redirect_valid & credit_ok;
   assign mem_req_addr  = pc_q;
   assign req_fire      = mem_req_valid & mem_req_ready;

   assign push = resp_ok & (state_q == RUN) & ~redirect_valid;
   assign drop = resp_ok & ~push;
   assign pop  = (count_q != '0) & inst_ready & ~redirect_valid;

   assign inst_valid = (count_q != '0);
   assign inst_data  = inst_valid ? q_data_q[rd_ptr_q] : '0;
   assign inst_pc    = inst_valid ? q_pc_q[rd_ptr_q]   : '0;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      discard_d = discard_q;
      outst_d   = outst_q + CW'(req_fire) - CW'(resp_ok);
      count_d   = count_q + CW'(push) - CW'(pop);
      wr_ptr_d  = wr_ptr_q + PW'(push);
      rd_ptr_d  = rd_ptr_q + PW'(pop);

      if (req_fire) begin
         pc_d = pc_q + ADDR_WIDTH'(4);
      end
      if (push) begin
         resp_pc_d = resp_pc_q + ADDR_WIDTH'(4);
      end

      if (redirect_valid) begin
         pc_d      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         resp_pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         count_d   = '0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         // A response landing in the redirect cycle is dropped here, not counted.
         discard_d = outst_q - CW'(resp_ok);
         state_d   = (discard_d != '0) ? DRAIN : RUN;
      end else if (state_q == DRAIN && resp_ok) begin
         discard_d = discard_q - CW'(1);
         if (discard_q == CW'(1)) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         outst_q   <= '0;
         discard_q <= '0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         outst_q   <= outst_d;
         discard_q <= discard_d;
         count_q   <= count_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         q_pc_q[wr_ptr_q]   <= resp_pc_q;
         q_data_q[wr_ptr_q] <= mem_resp_data;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] stat_fetched_q;
   logic [31:0] stat_discarded_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_fetched_q   <= '0;
         stat_discarded_q <= '0;
      end else begin
         if (pop && stat_fetched_q != 32'hFFFF_FFFF) begin
            stat_fetched_q <= stat_fetched_q + 32'd1;
         end
         if (drop && stat_discarded_q != 32'hFFFF_FFFF) begin
            stat_discarded_q <= stat_discarded_q + 32'd1;
         end
      end
   end

   assign stat_fetched   = stat_fetched_q;
   assign stat_discarded = stat_discarded_q;
`endif

   a_no_orphan_resp: assert property (@(posedge clock) disable iff (!reset)
      !(mem_resp_valid && outst_q == '0));

endmodule
